// File: rtl/reverb_pkg.sv
// ============================================================================
// Module  : reverb_pkg
// Brief   : Shared types and constants for the reverb MAC sequencer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package reverb_pkg;

    localparam int FRAC_BITS = 8;

    // Saturation limits for the default 24-bit data word
    localparam logic [23:0] MAX_POS = 24'h7FFFFF;
    localparam logic [23:0] MAX_NEG = 24'h800000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        ADD  = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/reverb_mac_alu.sv
// ============================================================================
// Module  : reverb_mac_alu
// Brief   : Combinational fixed-point multiply, add and overflow detection.
//           Saturation enabled by defining REVERB_SAT_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reverb_mac_alu
    import reverb_pkg::*;
#(
    parameter int N = 24
) (
    input  logic [N-1:0] mul_a,
    input  logic [N-1:0] mul_b,
    input  logic [N-1:0] add_a,
    input  logic [N-1:0] add_b,
    output logic [N-1:0] prod,
    output logic         mul_ovf,
    output logic [N-1:0] sum,
    output logic         add_ovf
);

    localparam logic [N-1:0] c_max_pos = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0] c_max_neg = {1'b1, {(N-1){1'b0}}};

    logic signed [2*N-1:0]        w_full;
    logic [N-1:0]                 w_trunc;
    logic [2*N-1:N-1+FRAC_BITS]   w_hi;
    logic [N-1:0]                 w_sum;
    logic                         w_unused_frac;

    assign w_full  = $signed({{N{mul_a[N-1]}}, mul_a}) * $signed({{N{mul_b[N-1]}}, mul_b});
    assign w_trunc = w_full[N-1+FRAC_BITS:FRAC_BITS];
    assign w_hi    = w_full[2*N-1:N-1+FRAC_BITS];
    // Fraction bits below the result LSB are dropped (floor truncation)
    assign w_unused_frac = ^w_full[FRAC_BITS-1:0];

    assign mul_ovf = ~((&w_hi) | ~(|w_hi));
    assign w_sum   = add_a + add_b;
    assign add_ovf = (add_a[N-1] == add_b[N-1]) && (w_sum[N-1] != add_a[N-1]);

`ifdef REVERB_SAT_EN
    assign prod = mul_ovf ? (w_full[2*N-1] ? c_max_neg : c_max_pos) : w_trunc;
    assign sum  = add_ovf ? (add_a[N-1] ? c_max_neg : c_max_pos) : w_sum;
`else
    assign prod = w_trunc;
    assign sum  = w_sum;
`endif

endmodule

`default_nettype wire

// File: rtl/reverb_mac_sequencer.sv
// ============================================================================
// Module  : reverb_mac_sequencer
// Brief   : Four-state sequencer computing y = x + alpha*d with handshakes.
//           Optional saturation via REVERB_SAT_EN (see reverb_mac_alu).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reverb_mac_sequencer
    import reverb_pkg::*;
#(
    parameter int N = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] x,
    input  logic [N-1:0] d,
    input  logic [N-1:0] alpha,
    output logic [N-1:0] y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         ovf,
    output logic [15:0]  sample_cnt
);

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_x;
    logic [N-1:0] r_d;
    logic [N-1:0] r_alpha;
    logic [N-1:0] r_p;
    logic [N-1:0] r_y;
    logic         r_mul_ovf;
    logic         r_ovf;
    logic [15:0]  r_cnt;

    logic [N-1:0] w_prod;
    logic [N-1:0] w_sum;
    logic         w_mul_ovf;
    logic         w_add_ovf;

    reverb_mac_alu #(.N(N)) u_alu (
        .mul_a   (r_alpha),
        .mul_b   (r_d),
        .add_a   (r_x),
        .add_b   (r_p),
        .prod    (w_prod),
        .mul_ovf (w_mul_ovf),
        .sum     (w_sum),
        .add_ovf (w_add_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next = MUL;
            MUL:     w_next = ADD;
            ADD:     w_next = OUT;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == IDLE);
        out_valid = (r_state == OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_d       <= '0;
            r_alpha   <= '0;
            r_p       <= '0;
            r_y       <= '0;
            r_mul_ovf <= 1'b0;
            r_ovf     <= 1'b0;
            r_cnt     <= 16'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_x       <= x;
                        r_d       <= d;
                        r_alpha   <= alpha;
                        r_mul_ovf <= 1'b0;
                        r_ovf     <= 1'b0;
                    end
                end
                MUL: begin
                    r_p       <= w_prod;
                    r_mul_ovf <= w_mul_ovf;
                end
                ADD: begin
                    r_y   <= w_sum;
                    r_ovf <= r_mul_ovf | w_add_ovf;
                end
                OUT: begin
                    if (out_ready) r_cnt <= r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign y          = r_y;
    assign ovf        = r_ovf;
    assign sample_cnt = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_reverb_mac_sequencer.sv
// ============================================================================
// Module  : tb_reverb_mac_sequencer
// Brief   : Self-checking bench with directed vectors and random operands
//           compared against an integer-arithmetic reference model.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reverb_mac_sequencer;
    import reverb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] x;
    logic [23:0] d;
    logic [23:0] alpha;
    logic [23:0] y;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;
    logic [15:0] sample_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_cnt = 16'd0;

    reverb_mac_sequencer #(.N(24)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .d          (d),
        .alpha      (alpha),
        .y          (y),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ovf        (ovf),
        .sample_cnt (sample_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Q.8 result computed as real integers: floor the product, then range-check
    task automatic ref_model(input logic [23:0] ax, ad, aa,
                             output logic [23:0] ey, output logic eo);
        longint pr, pt, pw, s;
        logic [23:0] pb;
        logic mo, ao;
        pr = longint'($signed(aa)) * longint'($signed(ad));
        pt = pr >>> 8;
        mo = (pt > 64'sd8388607) || (pt < -64'sd8388608);
`ifdef REVERB_SAT_EN
        if (mo) pw = (pr < 0) ? -64'sd8388608 : 64'sd8388607;
        else    pw = pt;
`else
        pb = pt[23:0];
        pw = longint'($signed(pb));
`endif
        s  = longint'($signed(ax)) + pw;
        ao = (s > 64'sd8388607) || (s < -64'sd8388608);
`ifdef REVERB_SAT_EN
        if (ao) ey = ax[23] ? MAX_NEG : MAX_POS;
        else    ey = s[23:0];
`else
        ey = s[23:0];
`endif
        eo = mo | ao;
    endtask

    task automatic scramble_inputs();
        logic [31:0] r;
        r = $urandom; x = r[23:0];
        r = $urandom; d = r[23:0];
        r = $urandom; alpha = r[23:0];
    endtask

    // Called #1 after a rising edge with the DUT idle
    task automatic run_op(input logic [23:0] ax, ad, aa, input int stall, input string tag);
        logic [23:0] ey;
        logic        eo;
        int          lat;
        ref_model(ax, ad, aa, ey, eo);
        chk({tag, ".in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        x = ax; d = ad; alpha = aa; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();
        lat = 0;
        while (!out_valid && lat < 10) begin
            chk({tag, ".in_ready_busy"}, {31'd0, in_ready}, 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, ".latency"}, lat, 32'd2);
        chk({tag, ".y"}, {8'd0, y}, {8'd0, ey});
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
        chk({tag, ".cnt_before"}, {16'd0, sample_cnt}, {16'd0, exp_cnt});
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            scramble_inputs();
            @(posedge clk); #1;
            chk({tag, ".stall_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, ".stall_y"}, {8'd0, y}, {8'd0, ey});
            chk({tag, ".stall_ovf"}, {31'd0, ovf}, {31'd0, eo});
            chk({tag, ".stall_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_cnt   = exp_cnt + 16'd1;
        chk({tag, ".done_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, ".done_ready"}, {31'd0, in_ready}, 32'd1);
        chk({tag, ".cnt_after"}, {16'd0, sample_cnt}, {16'd0, exp_cnt});
    endtask

    initial begin
        logic [31:0] r;
        logic [23:0] rx, rd, ra;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; d = '0; alpha = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset.y", {8'd0, y}, 32'd0);
        chk("reset.ovf", {31'd0, ovf}, 32'd0);
        chk("reset.cnt", {16'd0, sample_cnt}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(24'h000100, 24'h000040, 24'h000080, 0, "vec_pos");
        chk("vec_pos.y_const", {8'd0, y}, 32'h000120);
        chk("vec_pos.cnt_one", {16'd0, sample_cnt}, 32'd1);
        run_op(24'h000100, 24'hFFFFC0, 24'h000080, 1, "vec_neg");
        chk("vec_neg.y_const", {8'd0, y}, 32'h0000E0);
        run_op(24'h7FFF00, 24'h000100, 24'h000100, 5, "vec_ovf");
`ifdef REVERB_SAT_EN
        chk("vec_ovf.y_const", {8'd0, y}, {8'd0, MAX_POS});
`else
        chk("vec_ovf.y_const", {8'd0, y}, 32'h800000);
`endif
        chk("vec_ovf.ovf_const", {31'd0, ovf}, 32'd1);
        run_op(24'h000000, 24'h7FFFFF, 24'h7FFFFF, 0, "vec_mulovf");
        run_op(24'h800000, 24'hFFFF00, 24'h000100, 0, "vec_negovf");
        run_op(24'h000000, 24'hFFFFFF, 24'h000001, 0, "vec_floor");

        // Reset while in ADD discards the result; simultaneous in_valid loses
        x = 24'h000200; d = 24'h000100; alpha = 24'h000100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_add.busy", {31'd0, in_ready}, 32'd0);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rst_add.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_add.out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_add.y", {8'd0, y}, 32'd0);
        chk("rst_add.ovf", {31'd0, ovf}, 32'd0);
        exp_cnt = 16'd0;
        chk("rst_add.cnt", {16'd0, sample_cnt}, 32'd0);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("rst_prio.idle", {31'd0, in_ready}, 32'd1);
        chk("rst_prio.no_out", {31'd0, out_valid}, 32'd0);

        for (int n = 0; n < 150; n++) begin
            r = $urandom; rx = r[23:0];
            r = $urandom;
            if (r[0]) rd = r[23:0];
            else      rd = {{12{r[11]}}, r[11:0]};
            r = $urandom;
            if (r[1]) ra = r[23:0];
            else      ra = {{14{r[9]}}, r[9:0]};
            run_op(rx, rd, ra, $urandom_range(0, 3), "rand");
        end

        // Counter wrap: preload near the top, then complete two operations
        force dut.r_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_cnt;
        exp_cnt = 16'hFFFF;
        @(posedge clk); #1;
        run_op(24'h000010, 24'h000100, 24'h000100, 0, "wrap0");
        chk("wrap.zero", {16'd0, sample_cnt}, 32'd0);
        run_op(24'h000020, 24'h000100, 24'h000100, 0, "wrap1");
        chk("wrap.one", {16'd0, sample_cnt}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
